// File: rtl/mux_scan_n_to_1.sv
// Registered N-to-1 channel multiplexer with manual select and an auto-scan mode.
// In scan mode an internal channel counter sweeps all inputs, holding each one
// for DWELL enabled cycles. Outputs carry data, the channel tag, a valid flag and
// a one-cycle wrap pulse on the last output of each sweep.
module mux_scan_n_to_1 #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH*WIDTH-1:0]     in_i,
  input  logic [$clog2(N_CH)-1:0]   sel_i,
  input  logic                      mode_i,
  input  logic                      en_i,
  output logic [WIDTH-1:0]          out_o,
  output logic [$clog2(N_CH)-1:0]   out_ch_o,
  output logic                      out_valid_o,
  output logic                      wrap_o
);

  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W:0]   NumCh  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LastDw = DW_W'(DWELL - 1);

  logic [WIDTH-1:0] chans [N_CH];

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;
  logic [SEL_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic             mode_q, mode_d;

  // Scan position used this edge; a scan-entry edge behaves as if counters were zero.
  logic [SEL_W-1:0] cur_ch;
  logic [DW_W-1:0]  cur_dw;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    assign chans[k] = in_i[k*WIDTH +: WIDTH];
  end

  // Next-state for outputs, scan counters and registered mode.
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    ch_cnt_d    = ch_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    cur_ch      = mode_q ? ch_cnt_q : '0;
    cur_dw      = mode_q ? dwell_cnt_q : '0;

    if (en_i) begin
      mode_d = mode_i;
      if (!mode_i) begin
        out_ch_d = sel_i;
        if ({1'b0, sel_i} < NumCh) begin
          out_d       = chans[sel_i];
          out_valid_d = 1'b1;
        end else begin
          out_d = '0;
        end
      end else begin
        out_d       = chans[cur_ch];
        out_ch_d    = cur_ch;
        out_valid_d = 1'b1;
        wrap_d      = (cur_ch == LastCh) && (cur_dw == LastDw);
        if (cur_dw == LastDw) begin
          dwell_cnt_d = '0;
          ch_cnt_d    = (cur_ch == LastCh) ? '0 : cur_ch + SEL_W'(1);
        end else begin
          dwell_cnt_d = cur_dw + DW_W'(1);
          ch_cnt_d    = cur_ch;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      ch_cnt_q    <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      ch_cnt_q    <= ch_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign out_o       = out_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// Directed self-checking bench for mux_scan_n_to_1 (N_CH=4, WIDTH=8, DWELL=2).
module tb_mux_scan_n_to_1;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DWELL = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [N_CH*WIDTH-1:0] in_i;
  logic [1:0]            sel_i;
  logic                  mode_i;
  logic                  en_i;
  logic [WIDTH-1:0]      out_o;
  logic [1:0]            out_ch_o;
  logic                  out_valid_o;
  logic                  wrap_o;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [7:0] chan_tbl [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  mux_scan_n_to_1 #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .DWELL (DWELL)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_i        (in_i),
    .sel_i       (sel_i),
    .mode_i      (mode_i),
    .en_i        (en_i),
    .out_o       (out_o),
    .out_ch_o    (out_ch_o),
    .out_valid_o (out_valid_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Check a full scan-mode output beat.
  task automatic check_beat(input string tag, input int ch, input logic valid,
                            input logic wr);
    check({tag, ".out"}, {24'd0, out_o}, {24'd0, chan_tbl[ch]});
    check({tag, ".ch"}, {30'd0, out_ch_o}, ch);
    check({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, valid});
    check({tag, ".wrap"}, {31'd0, wrap_o}, {31'd0, wr});
  endtask

  int exp_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    in_i   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rst_i  = 1'b1;
    mode_i = 1'b1;
    en_i   = 1'b1;
    sel_i  = 2'd0;

    // 1. Reset dominates mode and en
    step();
    step();
    check("rst.out", {24'd0, out_o}, 32'd0);
    check("rst.ch", {30'd0, out_ch_o}, 32'd0);
    check("rst.valid", {31'd0, out_valid_o}, 32'd0);
    check("rst.wrap", {31'd0, wrap_o}, 32'd0);
    rst_i = 1'b0;
    step();
    check_beat("rst_rel", 0, 1'b1, 1'b0);

    // 2. Manual selection, one cycle latency
    mode_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel_i = 2'(s);
      step();
      check_beat($sformatf("man%0d", s), s, 1'b1, 1'b0);
    end

    // 3. Full sweep from scan entry, wrap only on the 8th output
    mode_i = 1'b1;
    sel_i  = 2'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      check_beat($sformatf("scan%0d", i), exp_ch[i], 1'b1, i == 7);
    end

    // 4. Pause mid-dwell on channel 2
    step(); check_beat("p_c1a", 1, 1'b1, 1'b0);
    step(); check_beat("p_c1b", 1, 1'b1, 1'b0);
    step(); check_beat("p_c2a", 2, 1'b1, 1'b0);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_beat($sformatf("hold%0d", i), 2, 1'b0, 1'b0);
    end
    en_i = 1'b1;
    step(); check_beat("p_c2b", 2, 1'b1, 1'b0);
    step(); check_beat("p_c3a", 3, 1'b1, 1'b0);
    step(); check_beat("p_c3b", 3, 1'b1, 1'b1);

    // 5. Leave scan for one manual cycle, re-entry restarts at channel 0
    for (int i = 0; i < 6; i++) step();
    step(); check_beat("r_c3", 3, 1'b1, 1'b0);
    mode_i = 1'b0;
    sel_i  = 2'd1;
    step(); check_beat("r_man", 1, 1'b1, 1'b0);
    mode_i = 1'b1;
    step(); check_beat("r_c0a", 0, 1'b1, 1'b0);
    step(); check_beat("r_c0b", 0, 1'b1, 1'b0);
    step(); check_beat("r_c1a", 1, 1'b1, 1'b0);

    // 6. Reset during channel 2, sweep restarts after release
    step(); check_beat("m_c1b", 1, 1'b1, 1'b0);
    step(); check_beat("m_c2a", 2, 1'b1, 1'b0);
    rst_i = 1'b1;
    step();
    check("mrst.out", {24'd0, out_o}, 32'd0);
    check("mrst.ch", {30'd0, out_ch_o}, 32'd0);
    check("mrst.valid", {31'd0, out_valid_o}, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_beat($sformatf("post%0d", i), exp_ch[i], 1'b1, i == 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
